// File: rtl/laser_pulse_monitor.sv
// Laser pulse on-time monitor: measures each light pulse in clk cycles and reports it against min/max limits.
// Optional LASER_MON_SYNC_EN inserts a two-flop synchronizer on the light input.
module laser_pulse_monitor #(
  parameter int unsigned NBITS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             light,
  input  logic [NBITS-1:0] min_cnt,
  input  logic [NBITS-1:0] max_cnt,
  input  logic             ack,
  output logic [NBITS-1:0] width,
  output logic             valid,
  output logic             ok,
  output logic             too_short,
  output logic             too_long,
  output logic             alarm,
  output logic             busy,
  output logic             missed
);

  typedef enum logic [1:0] {IDLE, MEASURE, REPORT} state_t;

  state_t           state, state_nxt;
  logic             light_s, prev, rise;
  logic [NBITS-1:0] cnt, cnt_nxt, cnt_inc;
  logic [NBITS-1:0] width_nxt;
  logic             valid_nxt, ok_nxt, too_short_nxt, too_long_nxt;
  logic             alarm_nxt, busy_nxt, missed_nxt;

`ifdef LASER_MON_SYNC_EN
  // Synchronizer resets high so a light already on at reset release never looks like a rise.
  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], light};
  end

  assign light_s = sync_q[1];
`else
  assign light_s = light;
`endif

  assign rise    = light_s & ~prev;
  assign cnt_inc = (cnt == '1) ? cnt : cnt + NBITS'(1);

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      prev      <= 1'b1;
      cnt       <= '0;
      width     <= '0;
      valid     <= 1'b0;
      ok        <= 1'b0;
      too_short <= 1'b0;
      too_long  <= 1'b0;
      alarm     <= 1'b0;
      busy      <= 1'b0;
      missed    <= 1'b0;
    end else begin
      state     <= state_nxt;
      prev      <= light_s;
      cnt       <= cnt_nxt;
      width     <= width_nxt;
      valid     <= valid_nxt;
      ok        <= ok_nxt;
      too_short <= too_short_nxt;
      too_long  <= too_long_nxt;
      alarm     <= alarm_nxt;
      busy      <= busy_nxt;
      missed    <= missed_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    width_nxt     = width;
    valid_nxt     = valid;
    ok_nxt        = ok;
    too_short_nxt = too_short;
    too_long_nxt  = too_long;
    alarm_nxt     = alarm;
    busy_nxt      = busy;
    missed_nxt    = 1'b0;

    case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = MEASURE;
          cnt_nxt   = NBITS'(1);
          busy_nxt  = 1'b1;
        end
      end
      MEASURE: begin
        if (light_s) begin
          cnt_nxt = cnt_inc;
          if (cnt_inc > max_cnt) alarm_nxt = 1'b1;
        end else begin
          // Pulse ended: freeze the count into the report.
          state_nxt     = REPORT;
          width_nxt     = cnt;
          valid_nxt     = 1'b1;
          busy_nxt      = 1'b0;
          alarm_nxt     = 1'b0;
          too_short_nxt = (cnt < min_cnt);
          too_long_nxt  = (cnt > max_cnt);
          ok_nxt        = !(cnt < min_cnt) && !(cnt > max_cnt);
        end
      end
      REPORT: begin
        // A new pulse cannot be measured until the report is consumed.
        if (rise) missed_nxt = 1'b1;
        if (valid && ack) begin
          state_nxt = IDLE;
          valid_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_laser_pulse_monitor.sv
// Self-checking bench for laser_pulse_monitor: directed scenarios plus randomized pulses against a per-pulse model.
module tb_laser_pulse_monitor;

  localparam int unsigned NB  = 8;
  localparam int          SAT = (1 << NB) - 1;
`ifdef LASER_MON_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic          clk = 1'b0;
  logic          reset, light, ack;
  logic [NB-1:0] min_cnt, max_cnt, width;
  logic          valid, ok, too_short, too_long, alarm, busy, missed;

  int checks   = 0;
  int failures = 0;

  logic [NB-1:0] e_width;
  logic          e_ok, e_ts, e_tl;

  always #5 clk = ~clk;

  laser_pulse_monitor #(.NBITS(NB)) dut (
    .clk(clk), .reset(reset), .light(light), .min_cnt(min_cnt), .max_cnt(max_cnt),
    .ack(ack), .width(width), .valid(valid), .ok(ok), .too_short(too_short),
    .too_long(too_long), .alarm(alarm), .busy(busy), .missed(missed)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected report for a pulse of len cycles under limits mn/mx.
  function automatic void model(input int len, input int mn, input int mx);
    int w;
    w       = (len > SAT) ? SAT : len;
    e_width = NB'(w);
    e_ts    = (w < mn);
    e_tl    = (w > mx);
    e_ok    = !e_ts && !e_tl;
  endfunction

  // Drive one pulse, check busy/alarm every cycle, then check the resulting report.
  task automatic pulse(input int len, input int mn, input int mx, input string tag);
    int   c;
    logic e_al;
    min_cnt = NB'(mn);
    max_cnt = NB'(mx);
    light   = 1'b1;
    for (int i = 1; i <= len; i++) begin
      step();
      if (i > LAT) begin
        c    = i - LAT;
        if (c > SAT) c = SAT;
        e_al = (c > mx);
        checks++;
        if ({busy, valid, alarm} !== {1'b1, 1'b0, e_al})
          $display("FAIL %s_meas cyc=%0d busy/valid/alarm got=%b exp=%b", tag, i,
                   {busy, valid, alarm}, {1'b1, 1'b0, e_al});
        if ({busy, valid, alarm} !== {1'b1, 1'b0, e_al}) failures++;
      end
    end
    light = 1'b0;
    for (int i = 0; i < LAT; i++) step();
    step();
    model(len, mn, mx);
    checks++;
    if ({valid, busy, alarm, ok, too_short, too_long, width} !==
        {1'b1, 1'b0, 1'b0, e_ok, e_ts, e_tl, e_width}) begin
      failures++;
      $display("FAIL %s_report v/b/a/ok/ts/tl/w got=%b%b%b%b%b%b %0d exp=1001%b%b%b %0d", tag,
               valid, busy, alarm, ok, too_short, too_long, width, e_ok, e_ts, e_tl, e_width);
    end
  endtask

  // Hold the report for some cycles with ack low, then accept it.
  task automatic ack_report(input int hold, input string tag);
    for (int i = 0; i < hold; i++) begin
      step();
      checks++;
      if ({valid, ok, too_short, too_long, width, busy, missed} !==
          {1'b1, e_ok, e_ts, e_tl, e_width, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL %s_hold cyc=%0d v/ok/ts/tl/w/b/m got=%b exp=%b", tag, i,
                 {valid, ok, too_short, too_long, width, busy, missed},
                 {1'b1, e_ok, e_ts, e_tl, e_width, 1'b0, 1'b0});
      end
    end
    ack = 1'b1;
    step();
    ack = 1'b0;
    checks++;
    if ({valid, busy, missed, alarm} !== 4'b0000) begin
      failures++;
      $display("FAIL %s_ack v/b/m/a got=%b exp=0000", tag, {valid, busy, missed, alarm});
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; light = 1'b0; ack = 1'b0; min_cnt = '0; max_cnt = '0;
    step(); step();
    checks++;
    if ({width, valid, ok, too_short, too_long, alarm, busy, missed} !== '0) begin
      failures++;
      $display("FAIL reset_state got=%b exp=0",
               {width, valid, ok, too_short, too_long, alarm, busy, missed});
    end
    reset = 1'b0;
    for (int i = 0; i < LAT + 2; i++) step();
    checks++;
    if ({valid, busy, missed} !== 3'b000) begin
      failures++;
      $display("FAIL reset_idle v/b/m got=%b exp=000", {valid, busy, missed});
    end
  endtask

  task automatic test_nominal();
    pulse(100, 90, 110, "nominal");
    ack_report(5, "nominal");
  endtask

  task automatic test_short_long();
    pulse(50, 90, 110, "short");
    ack_report(2, "short");
    pulse(120, 90, 110, "long");
    ack_report(0, "long");
  endtask

  task automatic test_boundaries();
    pulse(1, 1, 1, "one_cycle");
    ack_report(1, "one_cycle");
    pulse(90, 90, 110, "at_min");
    ack_report(0, "at_min");
    pulse(110, 90, 110, "at_max");
    ack_report(0, "at_max");
    pulse(50, 100, 20, "inverted");
    ack_report(1, "inverted");
    pulse(300, 10, 200, "saturate");
    ack_report(1, "saturate");
  endtask

  task automatic test_ack_idle();
    ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({valid, busy, missed} !== 3'b000) begin
        failures++;
        $display("FAIL ack_idle cyc=%0d v/b/m got=%b exp=000", i, {valid, busy, missed});
      end
    end
    ack = 1'b0;
    step();
  endtask

  task automatic test_missed();
    int mcount;
    pulse(30, 20, 40, "pre_missed");
    mcount = 0;
    for (int i = 0; i < 20; i++) begin
      light = (i >= 5 && i < 15);
      step();
      if (missed === 1'b1) mcount++;
      checks++;
      if ({valid, ok, too_short, too_long, width, busy} !== {1'b1, e_ok, e_ts, e_tl, e_width, 1'b0}) begin
        failures++;
        $display("FAIL missed_hold cyc=%0d v/ok/ts/tl/w/b got=%b exp=%b", i,
                 {valid, ok, too_short, too_long, width, busy},
                 {1'b1, e_ok, e_ts, e_tl, e_width, 1'b0});
      end
    end
    checks++;
    if (mcount !== 1) begin
      failures++;
      $display("FAIL missed_count got=%0d exp=1", mcount);
    end
    ack_report(0, "missed");
    pulse(7, 5, 10, "post_missed");
    ack_report(0, "post_missed");
  endtask

  task automatic test_missed_on_ack();
    pulse(12, 10, 15, "pre_ackrise");
    light = 1'b1;
    for (int i = 0; i < LAT; i++) step();
    ack = 1'b1;
    step();
    ack = 1'b0;
    checks++;
    if ({valid, busy, missed} !== 3'b001) begin
      failures++;
      $display("FAIL ackrise_strobe v/b/m got=%b exp=001", {valid, busy, missed});
    end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({valid, busy, missed} !== 3'b000) begin
        failures++;
        $display("FAIL ackrise_ignored cyc=%0d v/b/m got=%b exp=000", i, {valid, busy, missed});
      end
    end
    light = 1'b0;
    for (int i = 0; i < LAT + 2; i++) step();
    checks++;
    if ({valid, busy} !== 2'b00) begin
      failures++;
      $display("FAIL ackrise_noreport v/b got=%b exp=00", {valid, busy});
    end
    pulse(5, 1, 10, "post_ackrise");
    ack_report(0, "post_ackrise");
  endtask

  task automatic test_reset_high();
    light = 1'b1;
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if ({valid, busy, missed} !== 3'b000) begin
        failures++;
        $display("FAIL reset_high cyc=%0d v/b/m got=%b exp=000", i, {valid, busy, missed});
      end
    end
    light = 1'b0;
    for (int i = 0; i < LAT + 2; i++) begin
      step();
      checks++;
      if (valid !== 1'b0) begin
        failures++;
        $display("FAIL reset_high_fall cyc=%0d valid got=%b exp=0", i, valid);
      end
    end
    pulse(5, 1, 10, "after_reset_high");
    ack_report(1, "after_reset_high");
  endtask

  task automatic test_reset_mid();
    min_cnt = NB'(90);
    max_cnt = NB'(110);
    light   = 1'b1;
    for (int i = 0; i < 40; i++) step();
    reset = 1'b1;
    step();
    checks++;
    if ({width, valid, ok, too_short, too_long, alarm, busy, missed} !== '0) begin
      failures++;
      $display("FAIL reset_mid_state got=%b exp=0",
               {width, valid, ok, too_short, too_long, alarm, busy, missed});
    end
    reset = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      checks++;
      if ({valid, busy} !== 2'b00) begin
        failures++;
        $display("FAIL reset_mid_tail cyc=%0d v/b got=%b exp=00", i, {valid, busy});
      end
    end
    light = 1'b0;
    for (int i = 0; i < LAT + 3; i++) begin
      step();
      checks++;
      if (valid !== 1'b0) begin
        failures++;
        $display("FAIL reset_mid_noreport cyc=%0d valid got=%b exp=0", i, valid);
      end
    end
    pulse(10, 90, 110, "after_reset_mid");
    ack_report(2, "after_reset_mid");
  endtask

  task automatic test_random();
    int mn, mx, len;
    for (int n = 0; n < 25; n++) begin
      mx  = int'($urandom_range(1, 200));
      mn  = int'($urandom_range(0, 200));
      len = int'($urandom_range(1, 270));
      pulse(len, mn, mx, "random");
      ack_report(int'($urandom_range(0, 5)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_short_long();
    test_boundaries();
    test_ack_idle();
    test_missed();
    test_missed_on_ack();
    test_reset_high();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/laser_pulse_monitor.md
LASER_PULSE_MONITOR -- requirements
Module: laser_pulse_monitor

Interface
REQ-001 Parameter: NBITS, default 32, width of counter, thresholds and measured width.
REQ-002 clk  input  1  clock; all state changes on its rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 light  input  1  laser light pulse under measurement; high = laser on.
REQ-005 min_cnt  input  NBITS  minimum acceptable on-time in clk cycles; held stable while busy=1.
REQ-006 max_cnt  input  NBITS  maximum acceptable on-time in clk cycles; held stable while busy=1.
REQ-007 ack  input  1  consumer accepts the current report.
REQ-008 width  output  NBITS  measured on-time of the last completed pulse, in cycles.
REQ-009 valid  output  1  report (width, ok, too_short, too_long) available.
REQ-010 ok  output  1  min_cnt <= width <= max_cnt.
REQ-011 too_short  output  1  width < min_cnt.
REQ-012 too_long  output  1  width > max_cnt.
REQ-013 alarm  output  1  live over-exposure flag during a pulse.
REQ-014 busy  output  1  a pulse is being measured.
REQ-015 missed  output  1  one-cycle strobe: a pulse start was discarded.

Function
REQ-016 light_s = light, or the synchronized copy per REQ-031; prev = light_s registered; rise = light_s & ~prev.
REQ-017 States: IDLE, MEASURE, REPORT; all outputs registered.
REQ-018 IDLE: on rise -> MEASURE, cnt <= 1, busy <= 1; otherwise remain.
REQ-019 MEASURE, light_s=1: cnt <= cnt+1, saturating at all-ones (no wrap).
REQ-020 MEASURE, light_s=0: -> REPORT; width <= cnt; valid <= 1; busy <= 0; too_short, too_long, ok set from cnt per REQ-010..012, same edge.
REQ-021 Width = number of rising clk edges on which light_s sampled 1; a 100-cycle pulse reports 100, valid high 1 cycle after light_s falls.
REQ-022 alarm <= 1 on the edge cnt becomes > max_cnt while in MEASURE; held until the MEASURE->REPORT edge, then 0.
REQ-023 If min_cnt > max_cnt, too_short and too_long may both be 1; ok = 0.
REQ-024 REPORT: width/ok/too_short/too_long/valid held stable until valid & ack; then -> IDLE, valid <= 0 next edge.
REQ-025 ack while valid=0 is ignored.
REQ-026 rise while in REPORT (including the ack cycle): pulse discarded, missed = 1 for exactly one cycle; that pulse is never measured.
REQ-027 Pulse of 1 cycle: width = 1. Pulse longer than 2^NBITS-1: width = all-ones, too_long per compare.

Reset
REQ-028 reset=1 at a clk edge: state IDLE; cnt, width = 0; valid, ok, too_short, too_long, alarm, busy, missed = 0.
REQ-029 prev resets to 1, so a pulse already high at reset release is not measured.
REQ-030 reset mid-MEASURE or mid-REPORT aborts without producing or keeping a report.

Configuration
REQ-031 LASER_MON_SYNC_EN defined: light passes through a two-flop synchronizer (reset to 1) before light_s; all light-to-output latencies grow by 2 cycles; width unchanged.
REQ-032 LASER_MON_SYNC_EN undefined: light_s = light directly; light must be synchronous to clk.

Verification
REQ-033 min=90, max=110, light high 100 cycles -> width=100, ok=1, too_short=0, too_long=0, alarm never 1, valid until ack.
REQ-034 min=90, max=110, 50-cycle pulse -> width=50, too_short=1, ok=0; 120-cycle pulse -> alarm rises when cnt reaches 111, width=120, too_long=1.
REQ-035 Report pending, ack withheld 20 cycles, second 10-cycle pulse -> missed=1 one cycle, report unchanged; after ack, state IDLE, valid=0.
REQ-036 light held high through reset release, then low, then 5-cycle pulse -> only width=5 reported.
REQ-037 reset asserted at cycle 40 of a 100-cycle pulse -> all outputs 0, no report for that pulse; next 10-cycle pulse -> width=10.
REQ-038 With LASER_MON_SYNC_EN, 100-cycle pulse -> width=100, valid 3 cycles after light falls.
